// File: rtl/cpu_trace_checker.sv
// ============================================================================
// Module      : cpu_trace_checker
// Description : Compares retired-instruction samples (PC, Inst, Alu_Result)
//               against a preloaded expected trace and reports run status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_trace_checker #(
    parameter int         DATA_W      = 32,
    parameter int         DEPTH       = 64,
    parameter logic [2:0] MASK        = 3'b111,
    parameter bit         STOP_ON_ERR = 1'b0,
    parameter int         TIMEOUT     = 1024,
    parameter int         ERR_W       = 16,
    localparam int        ADDR_W      = $clog2(DEPTH)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Load_En,
    input  logic [ADDR_W-1:0]   Load_Addr,
    input  logic [3*DATA_W-1:0] Load_Data,
    input  logic                Start,
    input  logic [ADDR_W:0]     Trace_Len,
    input  logic                Valid,
    input  logic [DATA_W-1:0]   PC,
    input  logic [DATA_W-1:0]   Inst,
    input  logic [DATA_W-1:0]   Alu_Result,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic                Timeout,
    output logic [ADDR_W:0]     Checked_Count,
    output logic [ERR_W-1:0]    Err_Count,
    output logic [ADDR_W-1:0]   Err_Index,
    output logic [2:0]          Err_Field
);

    localparam int                TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]   c_to    = TO_W'(TIMEOUT);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_checked;
    logic [ERR_W-1:0]    r_err_cnt;
    logic [ADDR_W-1:0]   r_err_index;
    logic [2:0]          r_err_field;
    logic [TO_W-1:0]     r_idle_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [3*DATA_W-1:0] r_mem [DEPTH];

    logic [3*DATA_W-1:0] w_exp;
    logic [2:0]          w_mismatch;
    logic                w_err;
    logic [ADDR_W:0]     w_len;
    logic [TO_W-1:0]     w_idle_next;
    logic                w_load_ok;

    // The checked count doubles as the read index into the expected trace.
    assign w_exp       = r_mem[r_checked[ADDR_W-1:0]];
    assign w_mismatch  = MASK & {PC         != w_exp[3*DATA_W-1:2*DATA_W],
                                 Inst       != w_exp[2*DATA_W-1:DATA_W],
                                 Alu_Result != w_exp[DATA_W-1:0]};
    assign w_err       = (w_mismatch != 3'b000);
    assign w_len       = (Trace_Len > c_depth) ? c_depth : Trace_Len;
    assign w_idle_next = r_idle_cnt + 1'b1;
    assign w_load_ok   = Load_En && !Reset && (r_state != S_RUN)
                         && ({1'b0, Load_Addr} < c_depth);

    // Trace storage survives reset so a loaded trace can be rerun.
    always_ff @(posedge Clock) begin
        if (w_load_ok) begin
            r_mem[Load_Addr] <= Load_Data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_checked   <= '0;
            r_err_cnt   <= '0;
            r_err_index <= '0;
            r_err_field <= '0;
            r_idle_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (Valid) begin
                        r_checked  <= r_checked + 1'b1;
                        r_idle_cnt <= '0;
                        if (w_err) begin
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                            if (r_err_cnt == '0) begin
                                r_err_index <= r_checked[ADDR_W-1:0];
                                r_err_field <= w_mismatch;
                            end
                        end
                        // An abort on error outranks normal completion.
                        if (STOP_ON_ERR && w_err) begin
                            r_state <= S_FAIL;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b0;
                        end else if ((r_checked + 1'b1) == r_len) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_cnt == '0) && !w_err;
                        end
                    end else if (TIMEOUT > 0) begin
                        r_idle_cnt <= w_idle_next;
                        if (w_idle_next == c_to) begin
                            r_state   <= S_FAIL;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_pass    <= 1'b0;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (Start) begin
                        r_len       <= w_len;
                        r_checked   <= '0;
                        r_err_cnt   <= '0;
                        r_err_index <= '0;
                        r_err_field <= '0;
                        r_idle_cnt  <= '0;
                        r_timeout   <= 1'b0;
                        if (Trace_Len == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign Busy          = r_busy;
    assign Done          = r_done;
    assign Pass          = r_pass;
    assign Timeout       = r_timeout;
    assign Checked_Count = r_checked;
    assign Err_Count     = r_err_cnt;
    assign Err_Index     = r_err_index;
    assign Err_Field     = r_err_field;

endmodule

`default_nettype wire
